// File: rtl/console_tx.sv
// console_tx: memory-mapped console output with exit capture.
//
// The core writes bytes to offset 0x0; they are buffered in a circular FIFO
// and handed to the host-side sink one per out_valid/out_ready handshake.
// A write to offset 0x8 latches an exit code. exit_valid is raised only
// after every byte written before the exit request has been drained.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   MMIO request handshake
//   req_addr              byte offset (0x0 DATA/STATUS, 0x8 EXIT)
//   req_wen, req_wdata    write enable and write data
//   rsp_valid, rsp_rdata  one-cycle response pulse and read data
//   out_valid/out_ready   byte stream toward the sink
//   out_data              byte at FIFO head
//   exit_valid, exit_code sticky exit indication and latched exit value
//
// state      | meaning
// -----------+--------------------------------------------------------
// RUN        | normal operation, no exit requested
// EXIT_PEND  | exit requested, FIFO still draining, data still accepted
// DONE       | FIFO drained after exit, exit_valid high, writes dropped

module console_tx #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        exit_valid,
    output logic [31:0] exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        EXIT_PEND = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic [31:0]     exit_code_q;
    logic            exit_valid_q;
    logic            rsp_valid_q;
    logic [63:0]     rsp_rdata_q, rsp_rdata_d;

    logic is_data, is_exit, full, empty, accept, enq, deq, exit_wr;
    logic [63:0] status;

    // Upper write-data bits carry no meaning for this peripheral.
    logic unused_wdata;
    assign unused_wdata = ^req_wdata[63:32];

    always_comb begin
        is_data   = (req_addr == 4'h0);
        is_exit   = (req_addr == 4'h8);
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        // Only a DATA write into a full FIFO stalls; in DONE data is
        // dropped, so there is nothing to wait for.
        req_ready = !(req_wen && is_data && full && (state_q != DONE));
        accept    = req_valid && req_ready;
        enq       = accept && req_wen && is_data && (state_q != DONE);
        deq       = !empty && out_ready;
        exit_wr   = accept && req_wen && is_exit && (state_q != DONE);

        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = exit_valid_q;
        status[15:8]  = 8'(count_q);

        rsp_rdata_d = '0;
        if (!req_wen) begin
            if (is_data)      rsp_rdata_d = status;
            else if (is_exit) rsp_rdata_d = {32'h0, exit_code_q};
        end

        count_d  = count_q + CW'(enq) - CW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        rd_ptr_d = rd_ptr_q + AW'(deq);
    end

    // Storage is not reset; entries are only observable once enqueued.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= req_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            exit_code_q  <= '0;
            exit_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_rdata_q <= accept ? rsp_rdata_d : '0;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            case (state_q)
                RUN: begin
                    if (exit_wr) begin
                        exit_code_q <= req_wdata[31:0];
                        state_q     <= EXIT_PEND;
                    end
                end
                EXIT_PEND: begin
                    if (exit_wr) exit_code_q <= req_wdata[31:0];
                    // A same-cycle enqueue means a byte is still owed.
                    if (empty && !enq) begin
                        state_q      <= DONE;
                        exit_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign out_valid  = !empty;
    assign out_data   = mem_q[rd_ptr_q];
    assign exit_valid = exit_valid_q;
    assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_console_tx.sv
// Randomized and directed bench for console_tx against a queue-based model.
module tb_console_tx;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_addr = '0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        exit_valid;
    logic [31:0] exit_code;

    int total = 0;
    int bad   = 0;

    // Reference model: a byte queue plus exit bookkeeping.
    logic [7:0]  mq[$];
    bit          m_pend, m_done;
    logic [31:0] m_code;

    console_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .exit_valid(exit_valid), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pend = 0;
        m_done = 0;
        m_code = '0;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, then
    // check registered outputs just after the rising edge.
    task automatic cycle(input logic v, input logic w, input logic [3:0] a,
                         input logic [63:0] d, input logic ordy);
        logic        exp_ready, acc, enq, pend0;
        logic [63:0] exp_rd;
        int          n0;
        @(negedge clk);
        req_valid = v; req_wen = w; req_addr = a; req_wdata = d; out_ready = ordy;
        #1;
        n0 = mq.size();
        exp_ready = !(w && a == 4'h0 && n0 == DEPTH && !m_done);
        chk("req_ready", {63'h0, req_ready}, {63'h0, exp_ready});
        chk("out_valid", {63'h0, out_valid}, {63'h0, n0 != 0});
        if (n0 != 0) chk("out_data", {56'h0, out_data}, {56'h0, mq[0]});
        acc = v && exp_ready;
        exp_rd = '0;
        if (acc && !w) begin
            if (a == 4'h0) begin
                exp_rd[15:8] = 8'(n0);
                exp_rd[2]    = m_done;
                exp_rd[1]    = (n0 == 0);
                exp_rd[0]    = (n0 == DEPTH);
            end else if (a == 4'h8) begin
                exp_rd[31:0] = m_code;
            end
        end
        enq   = acc && w && a == 4'h0 && !m_done;
        pend0 = m_pend && !m_done;
        if (n0 != 0 && ordy) void'(mq.pop_front());
        if (enq) mq.push_back(d[7:0]);
        if (acc && w && a == 4'h8 && !m_done) begin
            m_code = d[31:0];
            m_pend = 1;
        end
        if (pend0 && n0 == 0 && !enq) m_done = 1;
        @(posedge clk);
        #1;
        chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, acc});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("exit_valid", {63'h0, exit_valid}, {63'h0, m_done});
        chk("exit_code", {32'h0, exit_code}, {32'h0, m_code});
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0;
        rst = 1;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_exit_valid", {63'h0, exit_valid}, 64'h0);
        chk("rst_exit_code", {32'h0, exit_code}, 64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(0, 0, 4'h0, 64'h0, ordy);
    endtask

    task automatic random_phase(input int n);
        logic [3:0] a;
        int r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 59));
            if (r < 40)      a = 4'h0;
            else if (r < 41) a = 4'h8;
            else             a = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, a,
                  {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        model_clear();
        do_reset();

        // Reset STATUS read.
        cycle(1, 0, 4'h0, 64'h0, 0);

        // "Hi\n" with the sink ready.
        cycle(1, 1, 4'h0, 64'hFFFF_FFFF_FFFF_FF48, 1);
        cycle(1, 1, 4'h0, 64'h69, 1);
        cycle(1, 1, 4'h0, 64'h0A, 1);
        idle(3, 1);
        cycle(1, 0, 4'h0, 64'h0, 1);

        // Fill to full, stall the 17th, release once, observe wrap.
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 4'h0, 64'(8'h30 + i), 0);
        cycle(1, 1, 4'h0, 64'hA5, 0);
        cycle(1, 0, 4'h0, 64'h0, 0);
        cycle(1, 1, 4'h0, 64'hA5, 1);
        cycle(1, 1, 4'h0, 64'hA5, 0);
        cycle(1, 0, 4'h0, 64'h0, 0);
        idle(DEPTH + 3, 1);

        // Exit with bytes pending.
        for (int i = 0; i < 5; i++) cycle(1, 1, 4'h0, 64'(8'h61 + i), 0);
        cycle(1, 1, 4'h8, 64'h2A, 0);
        idle(4, 0);
        idle(7, 1);
        cycle(1, 0, 4'h0, 64'h0, 1);
        cycle(1, 1, 4'h0, 64'h55, 1);
        idle(2, 1);
        cycle(1, 1, 4'h8, 64'h77, 1);
        cycle(1, 0, 4'h8, 64'h0, 1);

        // Exit on an empty FIFO, overwritten while pending.
        do_reset();
        cycle(1, 1, 4'h8, 64'h1234_5678_DEAD_BEEF, 0);
        cycle(1, 1, 4'h8, 64'h0000_0000_0000_0099, 0);
        idle(3, 0);

        // Reserved offsets.
        do_reset();
        cycle(1, 1, 4'h4, 64'hFF, 1);
        cycle(1, 0, 4'hC, 64'h0, 1);
        cycle(1, 0, 4'h0, 64'h0, 1);

        // Reset mid-drain.
        for (int i = 0; i < 8; i++) cycle(1, 1, 4'h0, 64'(8'hC0 + i), 0);
        cycle(0, 0, 4'h0, 64'h0, 1);
        do_reset();
        cycle(1, 0, 4'h0, 64'h0, 0);

        for (int k = 0; k < 3; k++) begin
            random_phase(600);
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
